// File: rtl/vga_sched_pkg.sv
// rtl/vga_sched_pkg.sv - shared types, gain limits and saturating gain helpers
package vga_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    localparam logic [7:0] GAIN_MAX = 8'd255;
    localparam logic [7:0] GAIN_MIN = 8'd0;

    // 9-bit difference; a borrow into bit 8 means the result went below black
    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[8] ? GAIN_MIN : diff[7:0];
    endfunction

    // 9-bit sum; a carry into bit 8 means the result went past full brightness
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? GAIN_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/vga_hold_timer.sv
// rtl/vga_hold_timer.sv - slideshow frame counter with expire pulse
module vga_hold_timer #(
    parameter logic [15:0] HOLD_FRAMES = 16'd360
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic i_frame_start,
    input  logic i_en,
    output logic o_expire
);

    logic [15:0] count;

    // Expiry is flagged on the frame start that completes the hold period
    assign o_expire = i_en && i_frame_start && (count == HOLD_FRAMES - 16'd1);

    // Count frame starts while enabled; disabling or clearing restarts the hold
    always_ff @(posedge clk) begin
        if (rst || clear || !i_en) begin
            count <= 16'd0;
        end else if (i_frame_start) begin
            count <= (count == HOLD_FRAMES - 16'd1) ? 16'd0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/vga_pic_scheduler.sv
// rtl/vga_pic_scheduler.sv - frame-aligned fade-out / swap / fade-in picture scheduler
module vga_pic_scheduler
    import vga_sched_pkg::*;
#(
    parameter int          NUM_PICS    = 2,
    parameter int          PIC_W       = 1,
    parameter logic [7:0]  FADE_STEP   = 8'd32,
    parameter logic [15:0] HOLD_FRAMES = 16'd360
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_frame_start,
    input  logic             i_req_valid,
    input  logic [PIC_W-1:0] i_req_pic,
    output logic             o_req_ready,
    input  logic             i_auto_en,
    output logic [PIC_W-1:0] o_pic_sel,
    output logic [7:0]       o_gain,
    output logic             o_busy,
    output logic             o_done
);

    state_t           state;
    logic [PIC_W-1:0] target;
    logic             accept;
    logic             expire;
    logic             req_fire;
    logic [PIC_W-1:0] ext_pic;
    logic [PIC_W-1:0] next_pic;
    logic [PIC_W-1:0] req_pic;
    logic [7:0]       gain_dn;
    logic [7:0]       gain_up;

    assign o_req_ready = (state == IDLE);
    assign o_busy      = (state != IDLE);
    assign accept      = i_req_valid && o_req_ready;

    // Out-of-range indices select the last stored picture
    assign ext_pic  = (int'(i_req_pic) >= NUM_PICS) ? PIC_W'(NUM_PICS - 1) : i_req_pic;
    assign next_pic = (int'(o_pic_sel) >= NUM_PICS - 1) ? '0 : o_pic_sel + PIC_W'(1);

    // External requests take priority over a slideshow expiry in the same cycle
    assign req_fire = accept || (o_req_ready && expire);
    assign req_pic  = accept ? ext_pic : next_pic;

    assign gain_dn = sat_sub8(o_gain, FADE_STEP);
    assign gain_up = sat_add8(o_gain, FADE_STEP);

    vga_hold_timer #(
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_hold_timer (
        .clk           (clk),
        .rst           (rst),
        .clear         (accept),
        .i_frame_start (i_frame_start),
        .i_en          (i_auto_en && o_req_ready),
        .o_expire      (expire)
    );

    // Transition sequencer; gain and select only move on frame starts
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            o_pic_sel <= '0;
            o_gain    <= GAIN_MAX;
            o_done    <= 1'b0;
            target    <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        target <= req_pic;
                        if (req_pic != o_pic_sel) begin
                            state <= FADE_OUT;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                FADE_OUT: begin
                    if (i_frame_start) begin
                        o_gain <= gain_dn;
                        if (gain_dn == GAIN_MIN) begin
                            state <= SWAP;
                        end
                    end
                end
                SWAP: begin
                    if (i_frame_start) begin
                        o_pic_sel <= target;
                        state     <= FADE_IN;
                    end
                end
                FADE_IN: begin
                    if (i_frame_start) begin
                        o_gain <= gain_up;
                        if (gain_up == GAIN_MAX) begin
                            state  <= IDLE;
                            o_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
